// File: rtl/mem_periph.sv
// -----------------------------------------------------------------------------
// mem_periph -- data memory and memory-mapped peripherals for the MEM stage.
//
// Address map (word accesses, Mem_in[1:0] ignored):
//   0x00000000 .. 4*RAM_WORDS-1 : data RAM (not cleared by reset)
//   0x40000000 : TH      timer reload value
//   0x40000004 : TL      timer counter
//   0x40000008 : TCON    bit0 enable, bit1 irq enable, bit2 irq status
//   0x4000000C : LED     8-bit LED register, read back zero-extended
//   0x40000014 : SYSTICK free-running read-only counter, present only when
//                the macro MEM_PERIPH_SYSTICK_EN is defined; otherwise unmapped
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   Mem_MemRd   read enable
//   Mem_MemWr   write enable
//   Mem_in      byte address
//   Mem_BusB    store data
//   Mem_RdData  combinational load data (0 when not reading or unmapped)
//   led         LED register
//   irqout      timer interrupt request (TCON[2] & TCON[1])
// -----------------------------------------------------------------------------
module mem_periph #(
    parameter int RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_MemRd,
    input  logic        Mem_MemWr,
    input  logic [31:0] Mem_in,
    input  logic [31:0] Mem_BusB,
    output logic [31:0] Mem_RdData,
    output logic [7:0]  led,
    output logic        irqout
);

    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
`ifdef MEM_PERIPH_SYSTICK_EN
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;
`endif

    logic [31:0] ram_r [RAM_WORDS];
    logic [31:0] th_r;
    logic [31:0] tl_r;
    logic [2:0]  tcon_r;
    logic [7:0]  led_r;
    logic        irq_r;
`ifdef MEM_PERIPH_SYSTICK_EN
    logic [31:0] systick_r;
    logic        sel_systick_s;
`endif

    logic [31:0]   addr_word_s;
    logic [AW-1:0] ram_idx_s;
    logic          sel_ram_s;
    logic          sel_th_s;
    logic          sel_tl_s;
    logic          sel_tcon_s;
    logic          sel_led_s;
    logic          wr_tl_s;
    logic          wr_tcon_s;
    logic [31:0]   tl_nxt_s;
    logic [2:0]    tcon_tmr_s;
    logic [2:0]    tcon_nxt_s;
    logic [31:0]   rd_data_s;
    logic          unused_addr_lsb_s;

    // Byte offset within a word carries no meaning: all accesses are words.
    assign unused_addr_lsb_s = ^Mem_in[1:0];

    // Address decode.
    assign addr_word_s = {Mem_in[31:2], 2'b00};
    assign ram_idx_s   = Mem_in[AW+1:2];
    assign sel_ram_s   = (Mem_in[31:AW+2] == '0);
    assign sel_th_s    = (addr_word_s == ADDR_TH);
    assign sel_tl_s    = (addr_word_s == ADDR_TL);
    assign sel_tcon_s  = (addr_word_s == ADDR_TCON);
    assign sel_led_s   = (addr_word_s == ADDR_LED);
`ifdef MEM_PERIPH_SYSTICK_EN
    assign sel_systick_s = (addr_word_s == ADDR_SYSTICK);
`endif

    assign wr_tl_s   = Mem_MemWr & sel_tl_s;
    assign wr_tcon_s = Mem_MemWr & sel_tcon_s;

    // Timer next-state: a CPU write to TL or TCON preempts the timer update.
    // A TL write also cancels the overflow event, so no status flag is raised.
    always_comb begin
        tl_nxt_s   = tl_r;
        tcon_tmr_s = tcon_r;
        if (wr_tl_s) begin
            tl_nxt_s = Mem_BusB;
        end else if (tcon_r[0]) begin
            if (tl_r == 32'hFFFF_FFFF) begin
                // Overflow reloads from TH instead of wrapping to zero.
                tl_nxt_s = th_r;
                if (tcon_r[1]) begin
                    tcon_tmr_s[2] = 1'b1;
                end else begin
                    tcon_tmr_s[2] = tcon_r[2];
                end
            end else begin
                tl_nxt_s = tl_r + 32'd1;
            end
        end else begin
            tl_nxt_s = tl_r;
        end

        if (wr_tcon_s) begin
            tcon_nxt_s = Mem_BusB[2:0];
        end else begin
            tcon_nxt_s = tcon_tmr_s;
        end
    end

    // Peripheral registers; irq is registered from the next TCON value so it
    // always equals TCON[2] & TCON[1] without a combinational output path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_r   <= 32'd0;
            tl_r   <= 32'd0;
            tcon_r <= 3'd0;
            led_r  <= 8'd0;
            irq_r  <= 1'b0;
        end else begin
            tl_r   <= tl_nxt_s;
            tcon_r <= tcon_nxt_s;
            irq_r  <= tcon_nxt_s[2] & tcon_nxt_s[1];
            if (Mem_MemWr && sel_th_s) begin
                th_r <= Mem_BusB;
            end
            if (Mem_MemWr && sel_led_s) begin
                led_r <= Mem_BusB[7:0];
            end
        end
    end

`ifdef MEM_PERIPH_SYSTICK_EN
    // Free-running system tick counter; wraps naturally, ignores writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick_r <= 32'd0;
        end else begin
            systick_r <= systick_r + 32'd1;
        end
    end
`endif

    // Data RAM: contents survive reset, but a write is dropped while reset is low.
    always_ff @(posedge clk) begin
        if (reset && Mem_MemWr && sel_ram_s) begin
            ram_r[ram_idx_s] <= Mem_BusB;
        end
    end

    // Combinational read mux; reads see pre-write values in a write cycle.
    always_comb begin
        rd_data_s = 32'd0;
        if (!Mem_MemRd) begin
            rd_data_s = 32'd0;
        end else if (sel_ram_s) begin
            rd_data_s = ram_r[ram_idx_s];
        end else if (sel_th_s) begin
            rd_data_s = th_r;
        end else if (sel_tl_s) begin
            rd_data_s = tl_r;
        end else if (sel_tcon_s) begin
            rd_data_s = {29'd0, tcon_r};
        end else if (sel_led_s) begin
            rd_data_s = {24'd0, led_r};
`ifdef MEM_PERIPH_SYSTICK_EN
        end else if (sel_systick_s) begin
            rd_data_s = systick_r;
`endif
        end else begin
            rd_data_s = 32'd0;
        end
    end

    assign Mem_RdData = rd_data_s;
    assign led        = led_r;
    assign irqout     = irq_r;

endmodule

// File: doc/mem_periph.md
MEM_PERIPH -- requirements
Module: mem_periph

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256: number of 32-bit data RAM words; must be a power of two, at most 256.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Mem_MemRd, input, 1 bit: read enable, driven by the EX/MEM register.
REQ-005 SHALL have port Mem_MemWr, input, 1 bit: write enable, driven by the EX/MEM register.
REQ-006 SHALL have port Mem_in, input, 32 bits: byte address (the EX-stage ALU result).
REQ-007 SHALL have port Mem_BusB, input, 32 bits: store data.
REQ-008 SHALL have port Mem_RdData, output, 32 bits: load data, feeding the MEM/WB register.
REQ-009 SHALL have port led, output, 8 bits: LED register contents.
REQ-010 SHALL have port irqout, output, 1 bit: timer interrupt request.

Function
REQ-011 SHALL decode the address as follows:
- 0x00000000 to 4*RAM_WORDS-1: RAM.
- 0x40000000: TH.
- 0x40000004: TL.
- 0x40000008: TCON.
- 0x4000000C: LED.
- 0x40000014: SYSTICK.
REQ-012 SHALL ignore Mem_in[1:0]; all accesses are word accesses.
REQ-013 SHALL return read data combinationally on Mem_RdData when Mem_MemRd=1, and drive 0 when Mem_MemRd=0 or the address is unmapped.
REQ-014 SHALL perform writes on the rising clk edge when Mem_MemWr=1; writes to unmapped addresses SHALL have no effect.
REQ-015 SHALL, when Mem_MemRd and Mem_MemWr are both 1 on the same address, return the pre-write value in that cycle.
REQ-016 SHALL use TCON bits as follows:
- bit0: timer enable.
- bit1: interrupt enable.
- bit2: interrupt status.
- bits[31:3]: read as 0.
REQ-017 SHALL, while TCON[0]=1, increment TL by 1 every cycle.
REQ-018 SHALL, when TL=0xFFFFFFFF and TCON[0]=1, reload TL with TH on the next edge (no wrap to 0), and set TCON[2] in the same edge if TCON[1]=1.
REQ-019 SHALL let a CPU write to TL or TCON in the same cycle as an increment or overflow win over the timer update.
REQ-020 SHALL hold TCON[2] set until software writes it.
REQ-021 SHALL drive irqout = TCON[2] & TCON[1].
REQ-022 SHALL latch the LED register from Mem_BusB[7:0] on write and read it back zero-extended.
REQ-023 SHALL make the RAM contents undefined after reset; reset SHALL NOT clear the RAM.

Reset
REQ-024 SHALL, while reset=0, asynchronously force TH, TL, TCON, LED and SYSTICK to 0, giving led=0 and irqout=0.
REQ-025 SHALL abort any write in progress when reset asserts mid-cycle; the timer SHALL restart from TL=0 disabled after release.

Configuration
REQ-026 SHALL gate SYSTICK with macro MEM_PERIPH_SYSTICK_EN:
- Defined: SYSTICK is a free-running 32-bit counter, +1 every cycle, wrapping 0xFFFFFFFF to 0; it is read-only and writes are ignored.
- Undefined: no counter is implemented and 0x40000014 is unmapped (reads 0).

Verification
REQ-027 SHALL cover: write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000013 -> Mem_RdData=0xDEADBEEF both times.
REQ-028 SHALL cover: TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3 -> TL reaches 0xFFFFFFFF, reloads 0xFFFFFFFD on the next edge, and irqout=1 from that edge onward; writing TCON=3 clears irqout.
REQ-029 SHALL cover: TCON=1 (interrupt disabled) with TL overflow -> TL reloads, TCON[2]=0, irqout=0.
REQ-030 SHALL cover: write TL=0x00000005 in the same cycle the timer is enabled and TL=0xFFFFFFFF -> TL=5 after the edge, no reload.
REQ-031 SHALL cover: write LED=0x1A5 -> led=0xA5; pulse reset low mid-cycle -> led=0 and TCON=0 immediately; read 0x40000020 -> 0.
REQ-032 SHALL cover: with MEM_PERIPH_SYSTICK_EN defined, two reads of 0x40000014 ten cycles apart differ by 10; with it undefined, both reads return 0.
